// File: rtl/branch_rs.sv
// Single-entry reservation station for conditional branches: captures an issued
// branch, snoops the ALU/LSU result buses for locked operands, and fires once.
package branch_rs_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned OP_W   = 6;

  localparam logic [TAG_W-1:0] UNLOCKED = TAG_W'(0);
  localparam logic [OP_W-1:0]  OP_NOP   = OP_W'(0);
endpackage

module branch_rs
  import branch_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue_en_in,
  input  logic [ADDR_W-1:0] issue_pc_in,
  input  logic [WORD_W-1:0] issue_offset_in,
  input  logic [OP_W-1:0]   issue_op_in,
  input  logic [TAG_W-1:0]  issue_tagx_in,
  input  logic [TAG_W-1:0]  issue_tagy_in,
  input  logic [WORD_W-1:0] issue_datax_in,
  input  logic [WORD_W-1:0] issue_datay_in,
  input  logic              alu_cdb_en_in,
  input  logic [TAG_W-1:0]  alu_cdb_tag_in,
  input  logic [WORD_W-1:0] alu_cdb_data_in,
  input  logic              lsu_cdb_en_in,
  input  logic [TAG_W-1:0]  lsu_cdb_tag_in,
  input  logic [WORD_W-1:0] lsu_cdb_data_in,
  output logic              rs_full_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [WORD_W-1:0] offset_out,
  output logic [OP_W-1:0]   branch_op_out,
  output logic [TAG_W-1:0]  branch_tagx_out,
  output logic [TAG_W-1:0]  branch_tagy_out,
  output logic [WORD_W-1:0] branch_datax_out,
  output logic [WORD_W-1:0] branch_datay_out,
  output logic              branch_busy_out
);

  typedef enum logic [1:0] {EMPTY, WAIT, FIRE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] off_q, off_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  tagx_q, tagx_d, tagy_q, tagy_d;
  logic [WORD_W-1:0] datax_q, datax_d, datay_q, datay_d;
  logic              full;

  // Resolve one operand against both buses; ALU has priority, unlocked tags never match.
  function automatic logic [TAG_W+WORD_W-1:0] resolve(
    input logic [TAG_W-1:0]  tag,
    input logic [WORD_W-1:0] data,
    input logic              a_en,
    input logic [TAG_W-1:0]  a_tag,
    input logic [WORD_W-1:0] a_data,
    input logic              l_en,
    input logic [TAG_W-1:0]  l_tag,
    input logic [WORD_W-1:0] l_data
  );
    logic [TAG_W+WORD_W-1:0] r;
    r = {tag, data};
    if (tag != UNLOCKED) begin
      if (a_en && (a_tag == tag)) begin
        r = {UNLOCKED, a_data};
      end else if (l_en && (l_tag == tag)) begin
        r = {UNLOCKED, l_data};
      end
    end
    return r;
  endfunction

  assign full = (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    off_d   = off_q;
    op_d    = op_q;
    tagx_d  = tagx_q;
    tagy_d  = tagy_q;
    datax_d = datax_q;
    datay_d = datay_q;
    if (rdy) begin
      case (state_q)
        FIRE: state_d = EMPTY;
        WAIT: begin
          {tagx_d, datax_d} = resolve(tagx_q, datax_q, alu_cdb_en_in, alu_cdb_tag_in,
                                      alu_cdb_data_in, lsu_cdb_en_in, lsu_cdb_tag_in,
                                      lsu_cdb_data_in);
          {tagy_d, datay_d} = resolve(tagy_q, datay_q, alu_cdb_en_in, alu_cdb_tag_in,
                                      alu_cdb_data_in, lsu_cdb_en_in, lsu_cdb_tag_in,
                                      lsu_cdb_data_in);
          state_d = ((tagx_d == UNLOCKED) && (tagy_d == UNLOCKED)) ? FIRE : WAIT;
        end
        default: ;
      endcase
      // Accepted in EMPTY or FIRE; the FIRE entry is consumed at this same edge.
      if (issue_en_in && !full) begin
        pc_d  = issue_pc_in;
        off_d = issue_offset_in;
        op_d  = issue_op_in;
        {tagx_d, datax_d} = resolve(issue_tagx_in, issue_datax_in, alu_cdb_en_in,
                                    alu_cdb_tag_in, alu_cdb_data_in, lsu_cdb_en_in,
                                    lsu_cdb_tag_in, lsu_cdb_data_in);
        {tagy_d, datay_d} = resolve(issue_tagy_in, issue_datay_in, alu_cdb_en_in,
                                    alu_cdb_tag_in, alu_cdb_data_in, lsu_cdb_en_in,
                                    lsu_cdb_tag_in, lsu_cdb_data_in);
        state_d = ((tagx_d == UNLOCKED) && (tagy_d == UNLOCKED)) ? FIRE : WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      off_q   <= '0;
      op_q    <= OP_NOP;
      tagx_q  <= UNLOCKED;
      tagy_q  <= UNLOCKED;
      datax_q <= '0;
      datay_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
      op_q    <= op_d;
      tagx_q  <= tagx_d;
      tagy_q  <= tagy_d;
      datax_q <= datax_d;
      datay_q <= datay_d;
    end
  end

  assign rs_full_out      = full;
  assign branch_busy_out  = (state_q != EMPTY);
  assign pc_out           = pc_q;
  assign offset_out       = off_q;
  assign branch_op_out    = op_q;
  assign branch_tagx_out  = tagx_q;
  assign branch_tagy_out  = tagy_q;
  assign branch_datax_out = datax_q;
  assign branch_datay_out = datay_q;

endmodule
